// File: rtl/seg_scan_if.sv
// Bundle for the multiplexed display bus and the six captured digit patterns.
// The master drives the scan side. The slave is the capture block.
interface seg_scan_if;
  logic       capture_en;
  logic [6:0] seg_in;
  logic [5:0] dig_sel;
  logic [6:0] x_0, x_1, x_2, y_0, y_1, y_2;
  logic       frame_valid, stale, onehot_err;

  modport master (output capture_en, seg_in, dig_sel,
                  input  x_0, x_1, x_2, y_0, y_1, y_2, frame_valid, stale, onehot_err);
  modport slave  (input  capture_en, seg_in, dig_sel,
                  output x_0, x_1, x_2, y_0, y_1, y_2, frame_valid, stale, onehot_err);
endinterface

// File: rtl/seg_scan_capture.sv
// Captures a 6-digit multiplexed seven-segment scan and commits frames that repeat identically.
// Optional macro SEG_CAPTURE_INVERT_EN: seg_in is active-high and is inverted after the synchronizer.
module seg_scan_capture #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int STABLE_FRAMES  = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic      clk,
  input  logic      rst_n,
  seg_scan_if.slave bus
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int MW = $clog2(STABLE_FRAMES + 1);
  localparam logic [6:0] DIG0 = 7'b1000000;

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  logic [6:0] seg_m_q, seg_s_q, seg_v;
  logic [5:0] dig_m_q, dig_s_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_m_q <= '0; seg_s_q <= '0; dig_m_q <= '0; dig_s_q <= '0;
    end else begin
      seg_m_q <= bus.seg_in;  seg_s_q <= seg_m_q;
      dig_m_q <= bus.dig_sel; dig_s_q <= dig_m_q;
    end
  end

`ifdef SEG_CAPTURE_INVERT_EN
  assign seg_v = ~seg_s_q;
`else
  assign seg_v = seg_s_q;
`endif

  logic multi, onehot;
  assign multi  = |(dig_s_q & (dig_s_q - 6'd1));
  assign onehot = (dig_s_q != 6'd0) && !multi;

  state_t        state_q, state_d;
  logic [5:0]    dig_q, dig_d;
  logic [6:0]    seg_q, seg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cap, start;

  // Digit FSM: a digit is captured once SETTLE_CYCLES identical samples are seen.
  always_comb begin
    state_d = state_q; dig_d = dig_q; seg_d = seg_q; cnt_d = cnt_q;
    cap = 1'b0; start = 1'b0;
    case (state_q)
      IDLE:   if (onehot) start = 1'b1;
      SETTLE: begin
        if (dig_s_q == dig_q && seg_v == seg_q) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(SETTLE_CYCLES - 1)) cap = 1'b1;
        end else if (onehot) start = 1'b1;
        else state_d = IDLE;
      end
      HOLD:   if (dig_s_q != dig_q) begin
        if (onehot) start = 1'b1;
        else state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (start) begin
      dig_d = dig_s_q; seg_d = seg_v; cnt_d = CW'(1);
      if (SETTLE_CYCLES == 1) cap = 1'b1;
      else state_d = SETTLE;
    end
    if (cap) state_d = HOLD;
    if (!bus.capture_en) begin
      state_d = IDLE; cap = 1'b0;
    end
  end

  logic [5:0][6:0] shadow_q, shadow_d, cand_q, cand_d, out_q, out_d;
  logic [5:0]      seen_q, seen_d;
  logic [MW-1:0]   match_q, match_d, m_next;
  logic [15:0]     tmo_q, tmo_d;
  logic            fv_q, fv_d, stale_q, stale_d, err_q, err_d, multi_q;

  // Frame tracking: compare each completed frame with the candidate, commit after enough repeats.
  always_comb begin
    shadow_d = shadow_q; cand_d = cand_q; out_d = out_q; seen_d = seen_q;
    match_d = match_q; m_next = match_q; tmo_d = tmo_q;
    fv_d = 1'b0; stale_d = stale_q;
    err_d = bus.capture_en && multi && !multi_q;
    if (!bus.capture_en) begin
      seen_d = '0; match_d = '0; tmo_d = '0;
    end else begin
      tmo_d = (tmo_q == 16'(TIMEOUT_CYCLES)) ? tmo_q : tmo_q + 16'd1;
      if (seen_q == 6'h3F) begin
        seen_d = '0; tmo_d = '0;
        if (shadow_q == cand_q)
          m_next = (match_q >= MW'(STABLE_FRAMES)) ? MW'(STABLE_FRAMES) : match_q + MW'(1);
        else begin
          cand_d = shadow_q; m_next = MW'(1);
        end
        match_d = m_next;
        if (m_next >= MW'(STABLE_FRAMES)) begin
          out_d = shadow_q; fv_d = 1'b1; stale_d = 1'b0;
        end
      end else if (tmo_d == 16'(TIMEOUT_CYCLES) && tmo_q != 16'(TIMEOUT_CYCLES)) begin
        stale_d = 1'b1; seen_d = '0; match_d = '0;
      end
      if (cap) begin
        for (int i = 0; i < 6; i++) if (dig_d[i]) shadow_d[i] = seg_d;
        seen_d = seen_d | dig_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE; dig_q <= '0; seg_q <= '0; cnt_q <= '0;
      shadow_q <= {6{DIG0}}; cand_q <= {6{DIG0}}; out_q <= {6{DIG0}};
      seen_q <= '0; match_q <= '0; tmo_q <= '0;
      fv_q <= 1'b0; stale_q <= 1'b0; err_q <= 1'b0; multi_q <= 1'b0;
    end else begin
      state_q <= state_d; dig_q <= dig_d; seg_q <= seg_d; cnt_q <= cnt_d;
      shadow_q <= shadow_d; cand_q <= cand_d; out_q <= out_d;
      seen_q <= seen_d; match_q <= match_d; tmo_q <= tmo_d;
      fv_q <= fv_d; stale_q <= stale_d; err_q <= err_d; multi_q <= multi;
    end
  end

  assign bus.x_0 = out_q[0];
  assign bus.x_1 = out_q[1];
  assign bus.x_2 = out_q[2];
  assign bus.y_0 = out_q[3];
  assign bus.y_1 = out_q[4];
  assign bus.y_2 = out_q[5];
  assign bus.frame_valid = fv_q;
  assign bus.stale       = stale_q;
  assign bus.onehot_err  = err_q;
endmodule
